// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches, queued CPU writes and one outstanding CPU read.
// Define VDP_ARB_READ_FWD_EN to serve pending CPU reads from the write queue when they hit.
module vdp_vram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_req,
    input  logic [13:0] vga_addr,
    output logic        vga_rvalid,
    output logic [7:0]  vga_rdata,
    input  logic        io_we,
    input  logic        io_re,
    input  logic [13:0] io_addr,
    input  logic [7:0]  io_wdata,
    output logic        io_rd_busy,
    output logic        io_rvalid,
    output logic [7:0]  io_rdata,
    output logic        io_wr_full,
    output logic        io_wr_ovf,
    input  logic        screen_busy,
    output logic        ram_en,
    output logic        ram_we,
    output logic [13:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);
    typedef enum logic [1:0] {GntIdle, GntVga, GntRd, GntWr} grant_e;

    grant_e      grant_d, grant_q;
    logic [13:0] fifo_addr_q [4];
    logic [7:0]  fifo_data_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        rd_busy_q;
    logic [13:0] rd_addr_q;
    logic        ovf_q;
    logic        vga_rvalid_q, io_rvalid_q;
    logic [7:0]  vga_rdata_q, io_rdata_q;

    logic        rd_pending, rd_eligible, fwd_hit;
    logic [7:0]  fwd_data;
    logic        push, pop;

    // A read already granted last cycle must not be granted again while its data is in flight.
    assign rd_pending = rd_busy_q && (grant_q != GntRd);

`ifdef VDP_ARB_READ_FWD_EN
    always_comb begin
        logic [1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        // Walk oldest to youngest so the last match wins.
        for (int unsigned i = 0; i < 4; i++) begin
            idx = rd_ptr_q + 2'(i);
            if ((3'(i) < count_q) && (fifo_addr_q[idx] == rd_addr_q)) begin
                fwd_hit  = rd_pending;
                fwd_data = fifo_data_q[idx];
            end
        end
    end
    assign rd_eligible = rd_pending && !fwd_hit;
`else
    assign fwd_hit     = 1'b0;
    assign fwd_data    = '0;
    assign rd_eligible = rd_pending && (count_q == 3'd0);
`endif

    always_comb begin
        grant_d = GntIdle;
        if (vga_req) begin
            grant_d = GntVga;
        end else if (rd_eligible && !screen_busy) begin
            grant_d = GntRd;
        end else if ((count_q != 3'd0) && !screen_busy) begin
            grant_d = GntWr;
        end
    end

    assign pop  = (grant_d == GntWr);
    assign push = io_we && ((count_q != 3'd4) || pop);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = vga_addr;
        ram_wdata = fifo_data_q[rd_ptr_q];
        if (!rst) begin
            unique case (grant_d)
                GntVga: ram_en = 1'b1;
                GntRd: begin
                    ram_en   = 1'b1;
                    ram_addr = rd_addr_q;
                end
                GntWr: begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = fifo_addr_q[rd_ptr_q];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= GntIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_busy_q    <= 1'b0;
            rd_addr_q    <= '0;
            ovf_q        <= 1'b0;
            vga_rvalid_q <= 1'b0;
            io_rvalid_q  <= 1'b0;
            vga_rdata_q  <= '0;
            io_rdata_q   <= '0;
        end else begin
            grant_q <= grant_d;
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= io_addr;
                fifo_data_q[wr_ptr_q] <= io_wdata;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + 3'(push) - 3'(pop);
            if (io_we && !push) begin
                ovf_q <= 1'b1;
            end

            // RAM data for last cycle's grant is valid now; present it next cycle.
            vga_rvalid_q <= (grant_q == GntVga);
            if (grant_q == GntVga) begin
                vga_rdata_q <= ram_rdata;
            end

            io_rvalid_q <= 1'b0;
            if (grant_q == GntRd) begin
                io_rvalid_q <= 1'b1;
                io_rdata_q  <= ram_rdata;
                rd_busy_q   <= 1'b0;
            end else if (fwd_hit) begin
                io_rvalid_q <= 1'b1;
                io_rdata_q  <= fwd_data;
                rd_busy_q   <= 1'b0;
            end else if (io_re && !rd_busy_q) begin
                rd_busy_q <= 1'b1;
                rd_addr_q <= io_addr;
            end
        end
    end

    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rdata_q;
    assign io_rvalid  = io_rvalid_q;
    assign io_rdata   = io_rdata_q;
    assign io_rd_busy = rd_busy_q;
    assign io_wr_full = (count_q == 3'd4);
    assign io_wr_ovf  = ovf_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_vdp_vram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        vga_req;
    logic [13:0] vga_addr;
    logic        vga_rvalid;
    logic [7:0]  vga_rdata;
    logic        io_we, io_re;
    logic [13:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_rd_busy, io_rvalid;
    logic [7:0]  io_rdata;
    logic        io_wr_full, io_wr_ovf;
    logic        screen_busy;
    logic        ram_en, ram_we;
    logic [13:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    vdp_vram_arbiter dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .io_we(io_we), .io_re(io_re), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rd_busy(io_rd_busy), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .io_wr_full(io_wr_full), .io_wr_ovf(io_wr_ovf), .screen_busy(screen_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM environment: unwritten locations read back a fixed address-derived pattern.
    logic [7:0] mem [16384];
    bit         written [16384];

    function automatic logic [7:0] init_val(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    function automatic logic [7:0] ram_peek(input logic [13:0] a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16384; i++) written[i] <= 1'b0;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= ram_peek(ram_addr);
            end
        end
    end

    typedef struct { int due; logic [7:0] data; } vexp_t;
    typedef struct { logic [13:0] addr; logic [7:0] data; } wr_t;

    vexp_t      vq[$];
    wr_t        wq[$];
    logic [7:0] rq[$];
    logic [7:0] shadow [logic [13:0]];

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          io_due = -1;
    int          rd_accesses = 0;
    bit          rd_pend = 1'b0;
    bit          exp_ovf = 1'b0;
    logic [13:0] pend_addr = '0;
    logic [13:0] last_wr_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        vga_req = 1'b0; vga_addr = '0; io_we = 1'b0; io_re = 1'b0;
        io_addr = '0; io_wdata = '0; screen_busy = 1'b0;
    endtask

    // Mid-cycle observation: checks outputs and advances the reference model by one cycle.
    task automatic sample();
        bit exp_v;
        bit popped;
        int occ;
        @(negedge clk);
        cycle++;
        exp_v = (vq.size() > 0) && (vq[0].due == cycle);
        chk("vga_rvalid", 32'(vga_rvalid), 32'(exp_v));
        if (exp_v) begin
            chk("vga_rdata", 32'(vga_rdata), 32'(vq[0].data));
            vq.delete(0);
        end
        if (io_due == cycle) chk("io_rvalid_rd_latency", 32'(io_rvalid), 32'd1);
        if (io_rvalid) begin
            chk("io_rvalid_expected", 32'(rq.size()), 32'd1);
            if (rq.size() > 0) begin
                chk("io_rdata", 32'(io_rdata), 32'(rq[0]));
                rq.delete(0);
            end
            rd_pend = 1'b0;
        end
        if (rst) begin
            chk("ram_en_in_reset", 32'(ram_en), 32'd0);
            chk("ram_we_in_reset", 32'(ram_we), 32'd0);
            vq.delete(); rq.delete(); wq.delete(); shadow.delete();
            rd_pend = 1'b0; exp_ovf = 1'b0; io_due = -1;
        end else begin
            chk("io_wr_ovf", 32'(io_wr_ovf), 32'(exp_ovf));
            occ = wq.size();
            chk("io_wr_full", 32'(io_wr_full), 32'(occ == 4));
            popped = 1'b0;
            if (vga_req) begin
                chk("vga_ram_en", 32'(ram_en), 32'd1);
                chk("vga_ram_we", 32'(ram_we), 32'd0);
                chk("vga_ram_addr", 32'(ram_addr), 32'(vga_addr));
                vq.push_back(vexp_t'{due: cycle + 2, data: ram_peek(vga_addr)});
            end else if (ram_en) begin
                chk("io_access_outside_screen", 32'(screen_busy), 32'd0);
                if (ram_we) begin
                    chk("wr_queue_nonempty", 32'(occ > 0), 32'd1);
                    if (occ > 0) begin
                        chk("wr_addr", 32'(ram_addr), 32'(wq[0].addr));
                        chk("wr_data", 32'(ram_wdata), 32'(wq[0].data));
                        wq.delete(0);
                        popped = 1'b1;
                    end
                    last_wr_addr = ram_addr;
                end else begin
                    chk("rd_addr", 32'(ram_addr), 32'(pend_addr));
                    rd_accesses++;
                    io_due = cycle + 2;
                end
            end
            if (io_we) begin
                if (occ < 4 || popped) begin
                    wq.push_back(wr_t'{addr: io_addr, data: io_wdata});
                    shadow[io_addr] = io_wdata;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (io_re && !rd_pend) begin
                rq.push_back(shadow.exists(io_addr) ? shadow[io_addr] : init_val(io_addr));
                rd_pend   = 1'b1;
                pend_addr = io_addr;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic settle();
        idle();
        for (int i = 0; i < 60 && (wq.size() > 0 || rq.size() > 0 || vq.size() > 0); i++) cyc();
        chk("settle_empty", 32'(wq.size() + rq.size() + vq.size()), 32'd0);
    endtask

    initial begin
        logic [13:0] a;
        int          base;
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        sample();
        chk("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
        chk("rst_io_rvalid", 32'(io_rvalid), 32'd0);
        chk("rst_rd_busy", 32'(io_rd_busy), 32'd0);
        chk("rst_wr_full", 32'(io_wr_full), 32'd0);
        chk("rst_wr_ovf", 32'(io_wr_ovf), 32'd0);
        chk("rst_vga_rdata", 32'(vga_rdata), 32'd0);
        chk("rst_io_rdata", 32'(io_rdata), 32'd0);
        adv();
        rst = 1'b0;
        cyc();

        // Single write reaches RAM the cycle after it is queued, then read it back.
        io_we = 1'b1; io_addr = 14'h0010; io_wdata = 8'hA5;
        cyc();
        idle();
        sample();
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'h0010);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
        adv();
        io_re = 1'b1; io_addr = 14'h0010;
        cyc();
        idle();
        sample();
        chk("rd_busy_set", 32'(io_rd_busy), 32'd1);
        adv();
        settle();

        // Five writes during active display: four queue, the fifth is dropped.
        screen_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            io_we = 1'b1; io_addr = 14'h0020 + 14'(i); io_wdata = 8'(i + 1);
            sample();
            chk("no_ram_in_screen", 32'(ram_en), 32'd0);
            adv();
        end
        io_we = 1'b0;
        sample();
        chk("fifo_full", 32'(io_wr_full), 32'd1);
        chk("fifo_ovf", 32'(io_wr_ovf), 32'd1);
        chk("fifo_no_ram", 32'(ram_en), 32'd0);
        adv();
        settle();

        // Display fetches starve a pending read until vga_req drops.
        vga_req = 1'b1; vga_addr = 14'($urandom); io_re = 1'b1; io_addr = 14'h0010;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("no_io_rvalid_under_vga", 32'(io_rvalid), 32'd0);
            if (i > 0) chk("rd_busy_under_vga", 32'(io_rd_busy), 32'd1);
            adv();
            io_re = 1'b0;
            vga_addr = 14'($urandom);
        end
        settle();

        // Write and read of the same address together: the read sees the new data.
        base = rd_accesses;
        io_we = 1'b1; io_re = 1'b1; io_addr = 14'h0200; io_wdata = 8'h3C;
        cyc();
        idle();
`ifdef VDP_ARB_READ_FWD_EN
        sample();
        chk("fwd_not_yet", 32'(io_rvalid), 32'd0);
        adv();
        sample();
        chk("fwd_rvalid", 32'(io_rvalid), 32'd1);
        adv();
`endif
        settle();
`ifdef VDP_ARB_READ_FWD_EN
        chk("fwd_no_ram_read", 32'(rd_accesses - base), 32'd0);
`endif
        chk("wr_then_rd_data", 32'(io_rdata), 32'h3C);

        // Reset right after an RD grant, with a write freshly queued.
        io_re = 1'b1; io_addr = 14'h0030;
        cyc();
        idle();
        io_we = 1'b1; io_addr = 14'h0031; io_wdata = 8'h99;
        sample();
        chk("rd_grant_en", 32'(ram_en), 32'd1);
        chk("rd_grant_we", 32'(ram_we), 32'd0);
        chk("rd_grant_addr", 32'(ram_addr), 32'h0030);
        adv();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("post_rst_busy", 32'(io_rd_busy), 32'd0);
            chk("post_rst_rvalid", 32'(io_rvalid), 32'd0);
            chk("post_rst_ram_en", 32'(ram_en), 32'd0);
            chk("post_rst_io_rdata", 32'(io_rdata), 32'd0);
            adv();
        end

        // Full queue with simultaneous enqueue and pop: accepted, drained last.
        screen_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io_we = 1'b1; io_addr = 14'h0040 + 14'(i); io_wdata = 8'(8'h50 + i);
            cyc();
        end
        screen_busy = 1'b0; io_we = 1'b1; io_addr = 14'h0044; io_wdata = 8'h77;
        cyc();
        io_we = 1'b0; screen_busy = 1'b1;
        sample();
        chk("full_after_push_pop", 32'(io_wr_full), 32'd1);
        chk("no_ovf_push_pop", 32'(io_wr_ovf), 32'd0);
        adv();
        settle();
        chk("new_entry_last", 32'(last_wr_addr), 32'h0044);

        // Random traffic on a small address window so the queue and reads interact.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            vga_req     = ($urandom_range(3) == 0);
            vga_addr    = 14'($urandom);
            screen_busy = ($urandom_range(2) == 0);
            io_we = 1'b0; io_re = 1'b0;
            a = 14'h0100 + 14'($urandom_range(7));
            if (wq.size() < 4 && $urandom_range(3) == 0 && !(rd_pend && a == pend_addr)) begin
                io_we    = 1'b1;
                io_wdata = 8'($urandom);
            end
            if ($urandom_range(5) == 0) io_re = 1'b1;
            io_addr = a;
            cyc();
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
